// File: rtl/ro_monitor_regulator_mc.sv
// ro_monitor_regulator_mc
//   Multi-channel ring-oscillator frequency monitor with a closed-loop PWM
//   supply regulator. Each channel counts synchronized RO rising edges over a
//   fixed window of clk_50MHz cycles, latches the count, and debounces a
//   "too slow" fail flag. A PWM output runs at a clamped duty set-point that
//   is trimmed upward while any channel is failing and relaxes back otherwise.
//
// Ports
//   clk_50MHz   system clock (rising edge)
//   rst         asynchronous active-high reset
//   ro_in       [CHANNELS] asynchronous ring-oscillator inputs (< 25 MHz)
//   fro_min     [CHANNELS*CNT_W] per-channel minimum count, ch i at [i*CNT_W +: CNT_W]
//   psi_min     duty bound A
//   psi_max     duty bound B (either order)
//   psi_set     requested duty
//   freq        [CHANNELS*CNT_W] last latched edge count per channel
//   fail        [CHANNELS] debounced per-channel fail
//   fail_any    OR of fail
//   meas_valid  one-cycle pulse: freq/fail just updated
//   psi         registered PWM output

// Per-channel monitor: synchronizer, saturating edge counter, count latch
// and low-window debounce.
module ro_monitor_chan #(
    parameter int CNT_W       = 8,
    parameter int FAIL_CONSEC = 2
) (
    input  logic             clk_50MHz,
    input  logic             rst,
    input  logic             ro,
    input  logic             term,
    input  logic [CNT_W-1:0] min_cnt,
    output logic [CNT_W-1:0] freq,
    output logic             fail,
    output logic             fail_nxt
);
    localparam int LOW_W = $clog2(FAIL_CONSEC + 1);

    logic [2:0]       sync;   // [0],[1] synchronizer, [2] edge-detect history
    logic             ro_rise;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [LOW_W-1:0] low, low_nxt;

    assign ro_rise = sync[1] & ~sync[2];

    // Saturate rather than wrap so an over-fast RO never reads as slow.
    always_comb begin
        cnt_nxt = cnt;
        if (ro_rise && cnt != '1) cnt_nxt = cnt + CNT_W'(1);
    end

    // Debounce uses the count being latched this cycle, edge included.
    always_comb begin
        low_nxt = low;
        if (cnt_nxt < min_cnt) begin
            if (low != LOW_W'(FAIL_CONSEC)) low_nxt = low + LOW_W'(1);
        end else begin
            low_nxt = '0;
        end
    end

    assign fail     = (low == LOW_W'(FAIL_CONSEC));
    assign fail_nxt = (low_nxt == LOW_W'(FAIL_CONSEC));

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            freq <= '0;
            low  <= '0;
        end else begin
            sync <= {sync[1:0], ro};
            if (term) begin
                freq <= cnt_nxt;
                cnt  <= '0;
                low  <= low_nxt;
            end else begin
                cnt <= cnt_nxt;
            end
        end
    end
endmodule

module ro_monitor_regulator_mc #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 8,
    parameter int WIN_CYCLES  = 256,
    parameter int FAIL_CONSEC = 2,
    parameter int PWM_W       = 8
) (
    input  logic                      clk_50MHz,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       ro_in,
    input  logic [CHANNELS*CNT_W-1:0] fro_min,
    input  logic [PWM_W-1:0]          psi_min,
    input  logic [PWM_W-1:0]          psi_max,
    input  logic [PWM_W-1:0]          psi_set,
    output logic [CHANNELS*CNT_W-1:0] freq,
    output logic [CHANNELS-1:0]       fail,
    output logic                      fail_any,
    output logic                      meas_valid,
    output logic                      psi
);
    localparam int WIN_W = $clog2(WIN_CYCLES);

    logic [WIN_W-1:0]    win;
    logic                term;
    logic [CHANNELS-1:0] fail_nxt;
    logic [PWM_W-1:0]    trim, lo, hi, target, pwm_cnt, duty_reg;
    logic [PWM_W:0]      sum;

    assign term = (win == WIN_W'(WIN_CYCLES - 1));

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        ro_monitor_chan #(
            .CNT_W      (CNT_W),
            .FAIL_CONSEC(FAIL_CONSEC)
        ) u_ch (
            .clk_50MHz(clk_50MHz),
            .rst      (rst),
            .ro       (ro_in[i]),
            .term     (term),
            .min_cnt  (fro_min[i*CNT_W +: CNT_W]),
            .freq     (freq[i*CNT_W +: CNT_W]),
            .fail     (fail[i]),
            .fail_nxt (fail_nxt[i])
        );
    end

    assign fail_any = |fail;

    // Clamp the trimmed set-point; one extra bit keeps the sum from wrapping.
    always_comb begin
        lo  = (psi_min < psi_max) ? psi_min : psi_max;
        hi  = (psi_min < psi_max) ? psi_max : psi_min;
        sum = {1'b0, psi_set} + {1'b0, trim};
        if (sum < {1'b0, lo})      target = lo;
        else if (sum > {1'b0, hi}) target = hi;
        else                       target = sum[PWM_W-1:0];
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            win        <= '0;
            meas_valid <= 1'b0;
            trim       <= '0;
            pwm_cnt    <= '0;
            duty_reg   <= '0;
            psi        <= 1'b0;
        end else begin
            win        <= term ? '0 : win + WIN_W'(1);
            meas_valid <= term;
            // Trim reacts to the fail state being latched this same cycle.
            if (term) begin
                if (|fail_nxt) begin
                    if (trim != '1) trim <= trim + PWM_W'(1);
                end else if (trim != '0) begin
                    trim <= trim - PWM_W'(1);
                end
            end
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            // Duty only changes at the period boundary: no mid-period glitch.
            if (pwm_cnt == '1) duty_reg <= target;
            psi <= (pwm_cnt < duty_reg);
        end
    end
endmodule

// File: doc/ro_monitor_regulator_mc.md
# ro_monitor_regulator_mc

Multi-channel ring-oscillator frequency monitor with closed-loop PWM supply regulator. Each channel counts rising edges of an asynchronous ring-oscillator input over a fixed gate window of system clocks. It compares the count against a per-channel minimum and raises debounced fail flags. A PWM output is driven with a clamped duty set-point, and the set-point is trimmed upward while any channel is failing. It replaces the single-channel monitor/regulator in the on-chip health-monitoring path.

## Interface
Parameters:
- CHANNELS, 4, number of ring-oscillator inputs
- CNT_W, 8, edge-counter width per channel (saturating)
- WIN_CYCLES, 256, gate window length in clk_50MHz cycles (≥4)
- FAIL_CONSEC, 2, consecutive low windows before a channel's fail asserts (≥1)
- PWM_W, 8, PWM counter and duty width

Ports:
- clk_50MHz  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- ro_in  input  CHANNELS  asynchronous ring-oscillator outputs
- fro_min  input  CHANNELS*CNT_W  per-channel minimum count; channel i at [i*CNT_W +: CNT_W]
- psi_min  input  PWM_W  duty bound A
- psi_max  input  PWM_W  duty bound B (A/B order not guaranteed)
- psi_set  input  PWM_W  requested duty
- freq  output  CHANNELS*CNT_W  last latched count per channel
- fail  output  CHANNELS  debounced per-channel fail
- fail_any  output  1  OR of fail
- meas_valid  output  1  one-cycle pulse: freq/fail just updated
- psi  output  1  PWM output

## Operation
- Input path per channel: 2-flop synchronizer, then a third flop for edge detect. Rising edge = sync2 & ~sync3. Valid only for RO frequency < 25 MHz.
- Window counter counts 0..WIN_CYCLES-1 and wraps. On the terminal cycle (win==WIN_CYCLES-1):
  - each edge counter's next value (including any edge detected in that cycle) is latched into freq;
  - edge counters clear to 0.
- Edge counters saturate at 2^CNT_W-1 and never wrap.
- Debounce: per channel, a low-counter increments when latched count < fro_min, saturating at FAIL_CONSEC, and clears when count ≥ fro_min. fail[i] = (low-counter == FAIL_CONSEC). Non-sticky: it clears on the first passing window.
- Bounds: lo = min(psi_min, psi_max), hi = max(psi_min, psi_max).
- Trim (PWM_W bits, saturating), updated once per window using the new fail value:
  - +1 if fail_any;
  - else -1 if trim > 0;
  - else hold.
- target = clamp(psi_set + trim, lo, hi). The sum is computed at PWM_W+1 bits, so no overflow before the clamp.
- PWM: free-running counter 0..2^PWM_W-1. duty_reg loads target only in the cycle the counter is at 2^PWM_W-1, so there are no mid-period glitches. psi = (pwm_cnt < duty_reg), registered.

## Timing
- Reset values: freq=0, fail=0, fail_any=0, meas_valid=0, psi=0. All internal counters, trim and duty_reg = 0.
- RO edge to counter increment: 3 clk_50MHz cycles.
- meas_valid asserts the cycle after the terminal window cycle. freq, fail and fail_any become valid in that same cycle. Trim updates in that cycle too.
- A trim change reaches psi at the next PWM period boundary: at most 2^PWM_W+1 cycles.
- An edge in the first cycle after the terminal cycle counts toward the new window.
- Counter saturation and the terminal cycle in the same cycle: the latched value is 2^CNT_W-1.
- fro_min=0: the channel can never fail.
- psi_set changing mid-period: takes effect at the next boundary only.
- lo==hi: duty fixed at lo regardless of trim.
- duty_reg=0: psi is constantly 0.
- duty_reg=2^PWM_W-1: psi is low for one cycle per period.
- rst mid-window: all state clears immediately. The first post-reset window is a full WIN_CYCLES long. No meas_valid until then.

## Test plan
- 20 MHz RO on ch0, WIN_CYCLES=256, fro_min[0]=90 -> freq[0]=102±1 each window; fail[0] stays 0; meas_valid pulses every 256 cycles.
- Same RO, fro_min[0]=110, FAIL_CONSEC=2 -> fail[0]=0 after window 1, fail[0]=1 and fail_any=1 after window 2. Then set fro_min=90 -> fail clears on the next meas_valid.
- CNT_W=6 with 20 MHz RO -> freq saturates at 63, no wrap. ro_in held at 0 -> freq=0.
- psi_min=160, psi_max=90, no failures; psi_set=70/125/180 -> psi high 90/125/160 cycles per 256-cycle period.
- Persistent failure with psi_set=125, hi=160 -> duty rises by 1 per window and holds at 160. Remove the failure -> trim decrements to 0 and duty returns to 125.
- Assert rst for 3 cycles mid-window and mid-PWM-period -> all outputs are 0 immediately. First meas_valid occurs 257 cycles after rst deasserts.
